// File: rtl/mux_pkg.sv
// Shared constants for the stream multiplexer family.
package mux_pkg;

   localparam int MODE_SEL = 0;
   localparam int MODE_RR  = 1;

   // Fallback for flows whose tools lack $clog2.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping at NUM_CH-1.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              grant_vld
);

   always_comb begin
      int idx;
      grant_idx = '0;
      grant_vld = 1'b0;
      // Walk from the farthest candidate back to ptr+1 so the nearest requester wins.
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NUM_CH;
         if (req[idx]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/stream_mux.sv
// Registered NUM_CH-to-1 valid/ready multiplexer; source picked by select_i or round-robin.
module stream_mux
   import mux_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int NUM_CH   = 4,
   parameter  int ARB_MODE = MODE_SEL,
   localparam int SEL_W    = $clog2(NUM_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_CH-1:0]        valid_i,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
   output logic [NUM_CH-1:0]        ready_o,
   input  logic [SEL_W-1:0]         select_i,
   output logic                     valid_o,
   output logic [DATA_W-1:0]        data_o,
   output logic [SEL_W-1:0]         ch_o,
   input  logic                     ready_i
);

   logic [NUM_CH-1:0] grant_oh;
   logic [SEL_W-1:0]  grant_idx;
   logic              grant_vld;
   logic              load;
   logic              xfer;

   assign load = !valid_o || ready_i;

   generate
      if (ARB_MODE == MODE_RR) begin : g_rr
         logic [SEL_W-1:0] ptr;
         logic             unused_select;

         assign unused_select = ^select_i;

         rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
            .req       (valid_i),
            .ptr       (ptr),
            .grant     (grant_oh),
            .grant_idx (grant_idx),
            .grant_vld (grant_vld)
         );

         // Reset value NUM_CH-1 gives channel 0 top priority on the first grant.
         always_ff @(posedge clk_i) begin
            if (rst_i)     ptr <= SEL_W'(NUM_CH - 1);
            else if (xfer) ptr <= grant_idx;
         end
      end else begin : g_sel
         always_comb begin
            grant_oh  = '0;
            grant_idx = '0;
            grant_vld = 1'b0;
            // Out-of-range selects match no channel and therefore never grant.
            for (int k = 0; k < NUM_CH; k++) begin
               if (int'(select_i) == k && valid_i[k]) begin
                  grant_oh[k] = 1'b1;
                  grant_idx   = SEL_W'(k);
                  grant_vld   = 1'b1;
               end
            end
         end
      end
   endgenerate

   // Held low during reset so no producer believes a word was taken.
   assign ready_o = (load && grant_vld && !rst_i) ? grant_oh : '0;
   assign xfer    = |ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         ch_o    <= '0;
      end else if (load) begin
         if (grant_vld) begin
            valid_o <= 1'b1;
            data_o  <= data_i[grant_idx*DATA_W +: DATA_W];
            ch_o    <= grant_idx;
         end else begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux.sv
// Drives a select-mode and a round-robin stream_mux from shared inputs against a reference model.
module tb_stream_mux;
   import mux_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   valid;
   logic [N*W-1:0] data;
   logic [1:0]     sel;
   logic           rdy;

   logic [N-1:0] ready_s, ready_r;
   logic         valid_s, valid_r;
   logic [W-1:0] data_s, data_r;
   logic [1:0]   ch_s, ch_r;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: index 0 = select mode, 1 = round-robin mode.
   bit       m_vld [2];
   bit [W-1:0] m_dat [2];
   int       m_ch  [2];
   int       m_ptr;

   always #5 clk = ~clk;

   stream_mux #(.DATA_W(W), .NUM_CH(N), .ARB_MODE(MODE_SEL)) dut_sel (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .ready_o(ready_s),
      .select_i(sel), .valid_o(valid_s), .data_o(data_s), .ch_o(ch_s), .ready_i(rdy)
   );

   stream_mux #(.DATA_W(W), .NUM_CH(N), .ARB_MODE(MODE_RR)) dut_rr (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .ready_o(ready_r),
      .select_i(sel), .valid_o(valid_r), .data_o(data_r), .ch_o(ch_r), .ready_i(rdy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int grant_of(input int mode);
      if (mode == 0) return valid[sel] ? int'(sel) : -1;
      for (int i = 1; i <= N; i++)
         if (valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   // One clock: check combinational ready, advance the model, check the register.
   task automatic cycle();
      int       g [2];
      bit       ld [2];
      bit [N-1:0] exp_rdy [2];
      #1;
      for (int m = 0; m < 2; m++) begin
         g[m]  = grant_of(m);
         ld[m] = !m_vld[m] || rdy;
         exp_rdy[m] = (!rst && ld[m] && g[m] >= 0) ? N'(1 << g[m]) : '0;
      end
      chk("ready_sel", 32'(ready_s), 32'(exp_rdy[0]));
      chk("ready_rr",  32'(ready_r), 32'(exp_rdy[1]));
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_vld[m] = 0; m_dat[m] = '0; m_ch[m] = 0;
            if (m == 1) m_ptr = N - 1;
         end else if (ld[m]) begin
            if (g[m] >= 0) begin
               m_vld[m] = 1; m_dat[m] = data[g[m]*W +: W]; m_ch[m] = g[m];
               if (m == 1) m_ptr = g[m];
            end else begin
               m_vld[m] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("valid_sel", 32'(valid_s), 32'(m_vld[0]));
      chk("data_sel",  data_s,       m_dat[0]);
      chk("ch_sel",    32'(ch_s),    32'(m_ch[0]));
      chk("valid_rr",  32'(valid_r), 32'(m_vld[1]));
      chk("data_rr",   data_r,       m_dat[1]);
      chk("ch_rr",     32'(ch_r),    32'(m_ch[1]));
   endtask

   task automatic fixed_data();
      for (int k = 0; k < N; k++) data[k*W +: W] = 32'hA000_0000 | W'(k);
   endtask

   task automatic rand_data();
      for (int k = 0; k < N; k++) data[k*W +: W] = $urandom;
   endtask

   initial begin
      m_vld = '{0, 0}; m_dat = '{0, 0}; m_ch = '{0, 0}; m_ptr = N - 1;
      rst = 1; valid = 4'b1111; sel = 0; rdy = 1; fixed_data();
      @(posedge clk);
      #1;

      // Reset held two cycles with everything valid.
      cycle(); cycle();
      chk("rst_valid", 32'(valid_r), 0);
      chk("rst_data",  data_r, 0);
      rst = 0;
      cycle();
      chk("rr_first_after_rst", 32'(ch_r), 0);

      // Select mode: channel 2, then an idle channel 3.
      sel = 2; valid = 4'b1111;
      cycle();
      chk("sel2_data", data_s, 32'hA000_0002);
      sel = 3; valid = 4'b0111;
      cycle();
      chk("sel3_bubble", 32'(valid_s), 0);

      // Round-robin fairness, then with channel 1 idle.
      valid = 4'b1111; rdy = 1;
      for (int i = 0; i < 8; i++) cycle();
      valid = 4'b1101;
      for (int i = 0; i < 6; i++) cycle();

      // Backpressure with channel 2 held in the register.
      rst = 1; cycle(); rst = 0;
      valid = 4'b0100; cycle();
      valid = 4'b1111; rdy = 0;
      for (int i = 0; i < 5; i++) cycle();
      chk("bp_hold_ch", 32'(ch_r), 2);
      rdy = 1; cycle();
      chk("bp_next_ch3", 32'(ch_r), 3);

      // Full-rate pass-through on channel 1.
      valid = 4'b0010; sel = 1;
      for (int i = 0; i < 6; i++) begin rand_data(); cycle(); end

      // Reset while a word is stalled in the register.
      valid = 4'b1111; rdy = 0; fixed_data(); cycle();
      rst = 1; cycle();
      chk("midrst_drop", 32'(valid_r), 0);
      rst = 0; rdy = 1; cycle();
      chk("midrst_first_ch0", 32'(ch_r), 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         valid = N'($urandom);
         sel   = 2'($urandom);
         rdy   = ($urandom_range(0, 9) < 7);
         rst   = ($urandom_range(0, 59) == 0);
         rand_data();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux.md
# stream_mux

Registered N-to-1 channel multiplexer with valid/ready handshakes, the parametrised successor of the datapath 2-to-1 select mux. It merges NUM_CH producer streams into one consumer stream and chooses the source either from an explicit select input or by round-robin arbitration. It is the building block for shared write-back and memory-request ports in the pipelined CPU.

## Interface
- DATA_W, 32, width of each data word
- NUM_CH, 4, number of input channels (2..16)
- ARB_MODE, 0, 0 = MODE_SEL (select_i picks channel), 1 = MODE_RR (round-robin)
- SEL_W, derived $clog2(NUM_CH), local, not overridable

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  **synchronous, active-high reset**
- valid_i  in  NUM_CH  per-channel valid; bit k belongs to channel k
- data_i  in  NUM_CH*DATA_W  flattened words; channel k occupies bits [k*DATA_W +: DATA_W]
- ready_o  out  NUM_CH  per-channel accept; at most one bit high per cycle
- select_i  in  SEL_W  channel choice, used only in MODE_SEL
- valid_o  out  1  output word valid
- data_o  out  DATA_W  output word
- ch_o  out  SEL_W  index of channel that produced data_o
- ready_i  in  1  consumer accept

## Operation
- One output register stage holds {valid_o, data_o, ch_o}.
- load = !valid_o || ready_i; a new word may enter only when load is high.
- Grant (combinational, at most one channel g):
  - MODE_SEL: g = select_i if select_i < NUM_CH and valid_i[select_i]; otherwise no grant. select_i >= NUM_CH never grants.
  - MODE_RR: g = first channel with valid_i set, searching upward from ptr+1 with wrap at NUM_CH-1 → 0; no grant if valid_i == 0.
- ready_o[g] = load && grant exists; all other ready_o bits 0. ready_o does not depend on ready_i except through load.
- Transfer on input k: valid_i[k] && ready_o[k] at the edge → data_o ← word k, ch_o ← k, valid_o ← 1.
- If load && no grant: valid_o ← 0 (data_o, ch_o hold last values).
- If !load: output register holds unchanged; data_o/ch_o stable while valid_o && !ready_i.
- ptr (MODE_RR only): updates to g on every input transfer; otherwise holds. With one channel persistently valid, it is granted every cycle.
- Reset: valid_o = 0, data_o = 0, ch_o = 0, ptr = NUM_CH-1 (channel 0 has highest priority after reset), ready_o = 0 while rst_i high. A word held in the register at reset is dropped.

## Timing
- Latency: input transfer at edge n → valid_o high after edge n, consumed at first edge with ready_i high.
- Throughput: one word per cycle when ready_i is held high.
- Output-side handshake is AXI-style: once valid_o rises it stays high with data_o stable until a cycle with ready_i high.
- Simultaneous output consume and new input transfer in the same cycle: the new word replaces the old one, with no bubble.
- Fairness: in MODE_RR with all NUM_CH channels continuously valid and ready_i = 1, grants cycle 0,1,…,NUM_CH-1,0,…
- rst_i asserted mid-transfer: the transfer is discarded, and the first post-reset cycle behaves as in the reset state.

## Structure
- Shared package mux_pkg: MODE_SEL = 0, MODE_RR = 1 constants; clog2 helper, if the toolchain lacks $clog2.
- Sub-module rr_arbiter (NUM_CH): inputs req, ptr; output one-hot grant plus encoded index. Instantiated only when ARB_MODE == MODE_RR (generate). The MODE_SEL path is a plain decode inside stream_mux.
- The top level holds the output register, the ptr register and the ready_o generation.

## Test plan
- Reset: assert rst_i 2 cycles with all valid_i = 1 → valid_o = 0, data_o = 0, ch_o = 0, ready_o = 0; first grant after release is ch 0 in MODE_RR.
- MODE_SEL, NUM_CH=4: valid_i = 4'b1111, data ch k = 32'hA000_000k, select_i = 2, ready_i = 1 → ready_o = 4'b0100; next cycle data_o = 32'hA000_0002, ch_o = 2. With select_i = 3 and valid_i[3] = 0 → no ready_o, valid_o falls.
- MODE_RR fairness: all 4 valid, ready_i = 1 for 8 cycles → ch_o sequence 0,1,2,3,0,1,2,3. Then drop valid_i[1] → sequence skips 1.
- Backpressure: word on ch 2 in register, ready_i = 0 for 5 cycles with all inputs valid → ready_o = 0, data_o/ch_o unchanged, ptr unchanged; ready_i = 1 → next grant is ch 3.
- Full-rate pass-through: single channel 1 valid every cycle, ready_i = 1 → ready_o[1] = 1 every cycle, data_o follows the input with 1-cycle delay and no bubbles.
- Reset mid-stream: rst_i pulses 1 cycle while valid_o = 1, ready_i = 0 → valid_o = 0 next cycle, word dropped, ptr = NUM_CH-1.
